// File: rtl/writeback_path_pkg.sv
// Shared definitions for the EX/MEM -> MEM/WB write-back path and the
// decode-side forwarding selects.
package writeback_path_pkg;

    // Encoding shared with decode's 3-input operand/branch-compare muxes.
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Pipeline-entry control flags; dest and data travel alongside at the
    // widths chosen by the instantiating module.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic overflow;
    } entry_ctl_t;

    // An entry may feed a forward only if it really writes a non-overflowed
    // value; EX/MEM additionally cannot supply load data (not yet read).
    function automatic logic can_forward(input entry_ctl_t ctl, input logic from_exmem);
        return ctl.valid && ctl.reg_write && !ctl.overflow && !(from_exmem && ctl.mem_to_reg);
    endfunction

endpackage

// File: rtl/writeback_path_fwd_select.sv
// Priority forwarding select for one decode source operand.
module fwd_select
    import writeback_path_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  entry_ctl_t        exmem_ctl,
    input  logic [REG_AW-1:0] exmem_dest,
    input  entry_ctl_t        memwb_ctl,
    input  logic [REG_AW-1:0] memwb_dest,
    output logic [1:0]        sel
);

    logic exmem_hit;
    logic memwb_hit;

    always_comb begin
        exmem_hit = can_forward(exmem_ctl, 1'b1) && (exmem_dest == src);
        memwb_hit = can_forward(memwb_ctl, 1'b0) && (memwb_dest == src);
    end

    // Register zero is never forwarded; the younger EX/MEM value wins.
    always_comb begin
        sel = FWD_REG;
        if (src != REG_AW'(REG_ZERO)) begin
            if (exmem_hit) begin
                sel = FWD_EXMEM;
            end else if (memwb_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/writeback_path.sv
// EX/MEM and MEM/WB pipeline registers, write-back port to the register file,
// decode forwarding selects and retire/overflow visibility counters.
module writeback_path
    import writeback_path_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EXValid,
    input  logic [DATA_W-1:0] EXALUResult,
    input  logic [REG_AW-1:0] EXWriteReg,
    input  logic              EXRegWrite,
    input  logic              EXMemtoReg,
    input  logic              EXOverflow,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic              MemWait,
    input  logic [REG_AW-1:0] IDRs,
    input  logic [REG_AW-1:0] IDRt,
    output logic [DATA_W-1:0] EXMEMALUResult,
    output logic [REG_AW-1:0] EXMEMWriteReg,
    output logic              EXMEMRegWrite,
    output logic              EXMEMMemtoReg,
    output logic [DATA_W-1:0] MemtoMux,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteRegEnable,
    output logic              MEMWBoverflow,
    output logic [1:0]        ForwardD,
    output logic [1:0]        ForwardE,
    output logic [31:0]       RetireCount,
    output logic [CNT_W-1:0]  OverflowCount
);

    entry_ctl_t        ex_ctl;
    entry_ctl_t        exmem_ctl;
    logic [REG_AW-1:0] exmem_dest;
    logic [DATA_W-1:0] exmem_data;

    entry_ctl_t        memwb_ctl;
    entry_ctl_t        memwb_ctl_next;
    logic [REG_AW-1:0] memwb_dest;
    logic [DATA_W-1:0] memwb_data;
    logic [DATA_W-1:0] mem_sel_data;

    logic [31:0]       retire_count;
    logic [CNT_W-1:0]  overflow_count;

    always_comb begin
        ex_ctl            = '0;
        ex_ctl.valid      = EXValid;
        ex_ctl.reg_write  = EXRegWrite;
        ex_ctl.mem_to_reg = EXMemtoReg;
        ex_ctl.overflow   = EXOverflow;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            exmem_ctl  <= '0;
            exmem_dest <= '0;
            exmem_data <= '0;
        end else if (!MemWait) begin
            exmem_ctl  <= ex_ctl;
            exmem_dest <= EXWriteReg;
            exmem_data <= EXALUResult;
        end
    end

    // A memory stall keeps EX/MEM frozen and pushes a bubble into MEM/WB.
    always_comb begin
        mem_sel_data   = exmem_ctl.mem_to_reg ? MemReadData : exmem_data;
        memwb_ctl_next = exmem_ctl;
        if (MemWait) begin
            memwb_ctl_next.valid     = 1'b0;
            memwb_ctl_next.reg_write = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            memwb_ctl  <= '0;
            memwb_dest <= '0;
            memwb_data <= '0;
        end else begin
            memwb_ctl <= memwb_ctl_next;
            if (!MemWait) begin
                memwb_dest <= exmem_dest;
                memwb_data <= mem_sel_data;
            end
        end
    end

    // Counters track the post-update MEM/WB contents, so they key off the
    // entry being loaded on this edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            retire_count   <= '0;
            overflow_count <= '0;
        end else begin
            if (memwb_ctl_next.valid) begin
                retire_count <= retire_count + 32'd1;
            end
            if (memwb_ctl_next.valid && memwb_ctl_next.overflow && (overflow_count != '1)) begin
                overflow_count <= overflow_count + 1'b1;
            end
        end
    end

    fwd_select #(
        .REG_AW(REG_AW)
    ) u_fwd_rs (
        .src       (IDRs),
        .exmem_ctl (exmem_ctl),
        .exmem_dest(exmem_dest),
        .memwb_ctl (memwb_ctl),
        .memwb_dest(memwb_dest),
        .sel       (ForwardD)
    );

    fwd_select #(
        .REG_AW(REG_AW)
    ) u_fwd_rt (
        .src       (IDRt),
        .exmem_ctl (exmem_ctl),
        .exmem_dest(exmem_dest),
        .memwb_ctl (memwb_ctl),
        .memwb_dest(memwb_dest),
        .sel       (ForwardE)
    );

    always_comb begin
        EXMEMALUResult = exmem_data;
        EXMEMWriteReg  = exmem_dest;
        EXMEMRegWrite  = exmem_ctl.valid && exmem_ctl.reg_write;
        EXMEMMemtoReg  = exmem_ctl.valid && exmem_ctl.mem_to_reg;
        MemtoMux       = memwb_data;
        WriteData      = memwb_data;
        WriteReg       = memwb_dest;
        // Overflow suppression is left to the register file.
        WriteRegEnable = memwb_ctl.valid && memwb_ctl.reg_write;
        MEMWBoverflow  = memwb_ctl.valid && memwb_ctl.overflow;
        RetireCount    = retire_count;
        OverflowCount  = overflow_count;
    end

endmodule

// File: tb/tb_writeback_path.sv
// Directed and randomized checks of writeback_path against a transaction-level
// model of the two pipeline slots and counters.
module tb_writeback_path;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned OVC_MAX = (1 << CNT_W) - 1;

    logic        Clk;
    logic        Rst;
    logic        EXValid;
    logic [31:0] EXALUResult;
    logic [4:0]  EXWriteReg;
    logic        EXRegWrite;
    logic        EXMemtoReg;
    logic        EXOverflow;
    logic [31:0] MemReadData;
    logic        MemWait;
    logic [4:0]  IDRs;
    logic [4:0]  IDRt;
    logic [31:0] EXMEMALUResult;
    logic [4:0]  EXMEMWriteReg;
    logic        EXMEMRegWrite;
    logic        EXMEMMemtoReg;
    logic [31:0] MemtoMux;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        WriteRegEnable;
    logic        MEMWBoverflow;
    logic [1:0]  ForwardD;
    logic [1:0]  ForwardE;
    logic [31:0] RetireCount;
    logic [CNT_W-1:0] OverflowCount;

    writeback_path #(
        .DATA_W(32),
        .REG_AW(5),
        .CNT_W (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .EXValid       (EXValid),
        .EXALUResult   (EXALUResult),
        .EXWriteReg    (EXWriteReg),
        .EXRegWrite    (EXRegWrite),
        .EXMemtoReg    (EXMemtoReg),
        .EXOverflow    (EXOverflow),
        .MemReadData   (MemReadData),
        .MemWait       (MemWait),
        .IDRs          (IDRs),
        .IDRt          (IDRt),
        .EXMEMALUResult(EXMEMALUResult),
        .EXMEMWriteReg (EXMEMWriteReg),
        .EXMEMRegWrite (EXMEMRegWrite),
        .EXMEMMemtoReg (EXMEMMemtoReg),
        .MemtoMux      (MemtoMux),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .WriteRegEnable(WriteRegEnable),
        .MEMWBoverflow (MEMWBoverflow),
        .ForwardD      (ForwardD),
        .ForwardE      (ForwardE),
        .RetireCount   (RetireCount),
        .OverflowCount (OverflowCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          valid;
        bit          rw;
        bit          mtr;
        bit          ovf;
        logic [4:0]  dest;
        logic [31:0] data;
    } instr_t;

    instr_t      m_em;
    instr_t      m_mw;
    logic [31:0] m_ret;
    int unsigned m_ovc;
    int          checks;
    int          failures;

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 0; e.rw = 0; e.mtr = 0; e.ovf = 0; e.dest = '0; e.data = '0;
        return e;
    endfunction

    task automatic model_reset();
        m_em  = empty_instr();
        m_mw  = empty_instr();
        m_ret = '0;
        m_ovc = 0;
    endtask

    // One clock edge as the spec describes it: the instruction in EX/MEM
    // retires into MEM/WB (unless the memory stalls), EX moves into EX/MEM.
    task automatic model_step();
        instr_t retiring;
        if (Rst) begin
            model_reset();
            return;
        end
        if (MemWait) begin
            m_mw.valid = 0;
            m_mw.rw    = 0;
        end else begin
            retiring = m_em;
            if (retiring.mtr) retiring.data = MemReadData;
            m_mw = retiring;
            m_em.valid = EXValid; m_em.rw = EXRegWrite; m_em.mtr = EXMemtoReg;
            m_em.ovf = EXOverflow; m_em.dest = EXWriteReg; m_em.data = EXALUResult;
        end
        if (m_mw.valid) begin
            m_ret = m_ret + 1;
            if (m_mw.ovf && m_ovc < OVC_MAX) m_ovc++;
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (m_em.valid && m_em.rw && !m_em.mtr && !m_em.ovf && m_em.dest == src) return 2'd1;
        if (m_mw.valid && m_mw.rw && !m_mw.ovf && m_mw.dest == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("exmem_alu", EXMEMALUResult, m_em.data);
        chk("exmem_wreg", EXMEMWriteReg, m_em.dest);
        chk("exmem_rw", EXMEMRegWrite, m_em.valid && m_em.rw);
        chk("exmem_mtr", EXMEMMemtoReg, m_em.valid && m_em.mtr);
        if (m_mw.valid) begin
            chk("wb_wreg", WriteReg, m_mw.dest);
            chk("wb_wdata", WriteData, m_mw.data);
            chk("wb_memtomux", MemtoMux, m_mw.data);
        end
        chk("wb_we", WriteRegEnable, m_mw.valid && m_mw.rw);
        chk("wb_ovf", MEMWBoverflow, m_mw.valid && m_mw.ovf);
        chk("fwd_d", ForwardD, exp_fwd(IDRs));
        chk("fwd_e", ForwardE, exp_fwd(IDRt));
        chk("retire_cnt", RetireCount, m_ret);
        chk("ovf_cnt", OverflowCount, m_ovc);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic set_ex(input bit v, input bit rw, input bit mtr, input bit ovf,
                          input logic [4:0] dest, input logic [31:0] data);
        EXValid = v; EXRegWrite = rw; EXMemtoReg = mtr; EXOverflow = ovf;
        EXWriteReg = dest; EXALUResult = data;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Rst = 1'b1;
        MemWait = 1'b0;
        MemReadData = '0;
        IDRs = '0;
        IDRt = '0;
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        model_reset();

        // Reset state
        @(posedge Clk);
        #1;
        check_all();
        chk("rst_memtomux", MemtoMux, 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_wreg", WriteReg, 5'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // ALU op to $9
        set_ex(1, 1, 0, 0, 5'd9, 32'h0000_0064);
        tick(); check_all();
        chk("alu_exmem", EXMEMALUResult, 32'd100);
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        tick(); check_all();
        chk("alu_wreg", WriteReg, 5'd9);
        chk("alu_wdata", WriteData, 32'd100);
        chk("alu_we", WriteRegEnable, 1'b1);
        chk("alu_retire", RetireCount, 32'd1);

        // Load to $12: no EX/MEM forward while in flight, MEM/WB forward after
        set_ex(1, 1, 1, 0, 5'd12, 32'h0000_0040);
        tick();
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        MemReadData = 32'hDEAD_BEEF;
        IDRs = 5'd12;
        #1; check_all();
        chk("ld_fwd_exmem", ForwardD, 2'd0);
        tick(); check_all();
        chk("ld_wdata", WriteData, 32'hDEAD_BEEF);
        chk("ld_fwd_memwb", ForwardD, 2'd2);

        // Forward priority on $8 and no forwarding of $0
        MemReadData = '0;
        set_ex(1, 1, 0, 0, 5'd8, 32'd5);
        tick();
        set_ex(1, 1, 0, 0, 5'd8, 32'd7);
        tick();
        IDRt = 5'd8;
        IDRs = 5'd0;
        #1; check_all();
        chk("prio_fwd_e", ForwardE, 2'd1);
        chk("prio_exmem", EXMEMALUResult, 32'd7);
        set_ex(1, 1, 0, 0, 5'd0, 32'd3);
        tick(); check_all();
        chk("zero_fwd_d", ForwardD, 2'd0);
        chk("older_fwd_e", ForwardE, 2'd2);

        // Overflowed result to $10
        set_ex(1, 1, 0, 1, 5'd10, 32'h7FFF_FFFF);
        tick();
        IDRs = 5'd10;
        IDRt = 5'd10;
        #1; check_all();
        chk("ovf_fwd_exmem", ForwardD, 2'd0);
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        tick(); check_all();
        chk("ovf_flag", MEMWBoverflow, 1'b1);
        chk("ovf_we", WriteRegEnable, 1'b1);
        chk("ovf_cnt1", OverflowCount, 3'd1);
        chk("ovf_fwd_memwb", ForwardE, 2'd0);

        // MemWait for 3 cycles with $11 in EX/MEM
        set_ex(1, 1, 0, 0, 5'd11, 32'h55);
        tick();
        MemWait = 1'b1;
        set_ex(1, 1, 0, 0, 5'd13, 32'h99);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
            chk("wait_we", WriteRegEnable, 1'b0);
            chk("wait_hold", EXMEMWriteReg, 5'd11);
        end
        MemWait = 1'b0;
        tick(); check_all();
        chk("wait_retire_reg", WriteReg, 5'd11);
        chk("wait_retire_we", WriteRegEnable, 1'b1);

        // Asynchronous reset in the middle of a stall
        set_ex(1, 1, 0, 0, 5'd15, 32'hAA);
        tick();
        MemWait = 1'b1;
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        tick();
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_retire", RetireCount, 32'd0);
        chk("arst_exmem_rw", EXMEMRegWrite, 1'b0);
        tick();
        Rst = 1'b0;
        MemWait = 1'b0;
        set_ex(1, 1, 0, 0, 5'd14, 32'h77);
        tick(); check_all();
        set_ex(0, 0, 0, 0, 5'd0, 32'd0);
        tick(); check_all();
        chk("post_rst_wreg", WriteReg, 5'd14);
        chk("post_rst_we", WriteRegEnable, 1'b1);
        chk("post_rst_retire", RetireCount, 32'd1);

        // Randomized traffic; small dest/source range makes hazards common
        for (int n = 0; n < 400; n++) begin
            set_ex(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom);
            MemReadData = $urandom;
            MemWait = ($urandom_range(0, 4) == 0);
            IDRs = 5'($urandom_range(0, 7));
            IDRt = 5'($urandom_range(0, 7));
            tick(); check_all();
        end
        chk("ovf_cnt_sat", OverflowCount, OVC_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
